// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Function : Multi-cycle load/store unit with a req/ack data-memory bus,
//            byte-lane steering, load extension and bus timeout.
//            Optional macro: MISALIGNED_TRAP_EN (trap misaligned H/W accesses).
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        access_fault,
    output logic        illegal,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam bit         TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        access_fault_q, access_fault_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic        tmo_expired;
    logic [1:0]  req_lane;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] load_sh;
    logic [31:0] load_ext;

    // Request decode, evaluated combinationally on the IDLE-cycle inputs.
    always_comb begin
        req_illegal = (funct3[1:0] == 2'b11) || (funct3[2] && (is_store || funct3[1]));
`ifdef MISALIGNED_TRAP_EN
        req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
`endif
        req_lane  = 2'b00;
        req_be    = 4'b0000;
        req_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                req_lane  = addr[1:0];
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_lane  = {addr[1], 1'b0};
                req_be    = 4'b0011 << {addr[1], 1'b0};
                req_wdata = {2{wdata[15:0]}};
            end
            2'b10: begin
                req_lane  = 2'b00;
                req_be    = 4'b1111;
                req_wdata = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_sh  = mem_rdata >> {lane_q, 3'b000};
        load_ext = load_sh;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_sh[7]}}, load_sh[7:0]};
            3'b100:  load_ext = {24'd0, load_sh[7:0]};
            3'b001:  load_ext = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b101:  load_ext = {16'd0, load_sh[15:0]};
            default: load_ext = load_sh;
        endcase
    end

    // An ack in the expiring cycle takes priority over the timeout.
    assign tmo_expired = TMO_EN && (tmo_cnt_q == TMO_LAST) && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            is_store_q     <= 1'b0;
            funct3_q       <= 3'd0;
            lane_q         <= 2'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_be_q       <= 4'd0;
            mem_wdata_q    <= 32'd0;
            rdata_q        <= 32'd0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            illegal_q      <= 1'b0;
            tmo_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            is_store_q     <= is_store_d;
            funct3_q       <= funct3_d;
            lane_q         <= lane_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            rdata_q        <= rdata_d;
            misaligned_q   <= misaligned_d;
            access_fault_q <= access_fault_d;
            illegal_q      <= illegal_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (req_illegal || req_misaligned) ? S_DONE : S_REQ;
            S_REQ:  if (mem_ack || tmo_expired) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_store_d     = is_store_q;
        funct3_d       = funct3_q;
        lane_d         = lane_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        rdata_d        = rdata_q;
        misaligned_d   = misaligned_q;
        access_fault_d = access_fault_q;
        illegal_d      = illegal_q;
        tmo_cnt_d      = tmo_cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                is_store_d     = is_store;
                funct3_d       = funct3;
                lane_d         = req_lane;
                mem_we_d       = is_store;
                mem_addr_d     = {addr[31:2], 2'b00};
                mem_be_d       = req_be;
                mem_wdata_d    = req_wdata;
                rdata_d        = 32'd0;
                illegal_d      = req_illegal;
                misaligned_d   = !req_illegal && req_misaligned;
                access_fault_d = 1'b0;
                tmo_cnt_d      = 8'd0;
            end
            S_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (mem_ack)          rdata_d = is_store_q ? 32'd0 : load_ext;
                else if (tmo_expired) access_fault_d = 1'b1;
            end
            S_DONE: begin
                rdata_d        = 32'd0;
                misaligned_d   = 1'b0;
                access_fault_d = 1'b0;
                illegal_d      = 1'b0;
                tmo_cnt_d      = 8'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        mem_req      = (state_q == S_REQ);
        mem_we       = mem_we_q;
        mem_addr     = mem_addr_q;
        mem_be       = mem_be_q;
        mem_wdata    = mem_wdata_q;
        rdata        = rdata_q;
        misaligned   = misaligned_q;
        access_fault = access_fault_q;
        illegal      = illegal_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Function : Self-checking bench for lsu: directed and randomized accesses
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    localparam int T = 4;
`ifdef MISALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misaligned, access_fault, illegal;
    logic        mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int total = 0;
    int bad = 0;

    lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misaligned(misaligned), .access_fault(access_fault),
        .illegal(illegal), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; dly = number of REQ cycles before ack (dly >= T means no ack).
    task automatic run(input bit st, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] rd, input int dly);
        bit ill, mis, acked;
        int sz, off;
        longint mask, v;
        bit [31:0] exp_be, exp_wd, exp_rd;
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
        sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        mis = TRAP && !ill && ((a % sz) != 0);
        off = (a % 4) - ((a % 4) % sz);
        mask = (64'd1 << (8 * sz)) - 1;
        exp_be = 32'(((1 << sz) - 1) << off);
        exp_wd = 0;
        for (int i = 0; i < 4 / sz; i++) exp_wd |= 32'((longint'(wd) & mask) << (8 * sz * i));
        v = (longint'(rd) >> (8 * off)) & mask;
        if (f3 < 4 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        exp_rd = st ? 32'd0 : v[31:0];
        acked = (dly < T);

        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_done", done, 0);
        @(posedge clk); #1;
        start = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        if (ill || mis) begin
            @(negedge clk);
            chk("early_done", done, 1);
            chk("early_req", mem_req, 0);
            chk("early_illegal", illegal, ill);
            chk("early_misaligned", misaligned, mis);
            chk("early_fault", access_fault, 0);
            chk("early_rdata", rdata, 0);
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c < T; c++) begin
            mem_ack = (c == dly);
            mem_rdata = mem_ack ? rd : $urandom;
            start = 1'($urandom);
            @(negedge clk);
            chk("req_req", mem_req, 1);
            chk("req_done", done, 0);
            chk("req_we", mem_we, st);
            chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("req_be", mem_be, exp_be);
            if (st) chk("req_wdata", mem_wdata, exp_wd);
            @(posedge clk); #1;
            mem_ack = 1'b0; start = 1'b0;
            if (c == dly) break;
        end
        @(negedge clk);
        chk("done_done", done, 1);
        chk("done_busy", busy, 1);
        chk("done_req", mem_req, 0);
        chk("done_rdata", rdata, acked ? exp_rd : 32'd0);
        chk("done_fault", access_fault, !acked);
        chk("done_illegal", illegal, 0);
        chk("done_misaligned", misaligned, 0);
        // Stray ack and start while in DONE must both be ignored.
        mem_ack = 1'b1; start = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_flags", {misaligned, access_fault, illegal}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0);
        run(1'b0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 1);
        run(1'b1, 3'b000, 32'h11, 32'h123456AB, 32'h0, 2);
        run(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0);
        run(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, 32'h0, T);
        run(1'b0, 3'b001, 32'h3006, 32'h0, 32'h9ABC0000, T - 1);
        run(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 0);
        run(1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 0);

        // Reset in the middle of a request.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("prerst_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_busy", busy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_nodone", done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 3'b010, 32'h80, 32'h0, 32'h13572468, 1);

        for (int i = 0; i < 120; i++)
            run(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, T));

        @(negedge clk);
        chk("final_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
